// File: rtl/paddle_encoder.sv
// -----------------------------------------------------------------------------
// paddle_encoder
//
// Turns the raw quadrature pins of one player's rotary encoder into a paddle
// row for the pong core. Each pin is synchronised (2 flops) and debounced
// (a change is accepted only after 2^DEBOUNCEWIDTH consecutive differing
// cycles). The filtered A/B pair is then decoded into quarter steps. Four
// quarter steps in one direction make a detent, which emits a one-cycle step
// pulse and moves the saturating paddle position.
//
// Ports:
//   clk32mhz  in   system clock
//   reset_n   in   synchronous reset, active low
//   enc_a     in   raw encoder channel A (asynchronous pad)
//   enc_b     in   raw encoder channel B (asynchronous pad)
//   center    in   load PADDLE_INIT; wins over steps and hold
//   hold      in   freeze position; decoding and pulses continue
//   position  out  paddle row, 0..PADDLE_MAX
//   step_up   out  one-cycle pulse per completed CW detent
//   step_down out  one-cycle pulse per completed CCW detent
//   err       out  one-cycle pulse when A and B are accepted together
// -----------------------------------------------------------------------------
module paddle_encoder #(
    parameter int DEBOUNCEWIDTH = 10,
    parameter int POSWIDTH      = 4,
    parameter int PADDLE_MAX    = 13,
    parameter int PADDLE_INIT   = 6
) (
    input  logic                clk32mhz,
    input  logic                reset_n,
    input  logic                enc_a,
    input  logic                enc_b,
    input  logic                center,
    input  logic                hold,
    output logic [POSWIDTH-1:0] position,
    output logic                step_up,
    output logic                step_down,
    output logic                err
);

    localparam logic [POSWIDTH-1:0] POS_MAX   = POSWIDTH'(PADDLE_MAX);
    localparam logic [POSWIDTH-1:0] POS_INIT  = POSWIDTH'(PADDLE_INIT);
    localparam logic [POSWIDTH-1:0] POS_ONE   = POSWIDTH'(1);
    localparam logic [1:0]          WARM_DONE = 2'd3;

    // Pin vectors: bit 1 = channel A, bit 0 = channel B.
    logic [1:0]               meta_q, sync_q;
    logic [1:0]               filt_q, filt_d;
    logic [1:0]               filt_prev_q, filt_prev_d;
    logic [DEBOUNCEWIDTH-1:0] cnt_q [2];
    logic [DEBOUNCEWIDTH-1:0] cnt_d [2];
    logic [1:0]               warm_q, warm_d;
    logic                     warm_active;
    logic signed [2:0]        quarter_q, quarter_d;
    logic [1:0]               delta;
    logic                     step_up_q, step_up_d;
    logic                     step_down_q, step_down_d;
    logic                     err_q, err_d;
    logic [POSWIDTH-1:0]      position_q, position_d;

    // Position of a code along the CW cycle 00->01->11->10 (a Gray-to-binary
    // conversion), so one CW quarter step is always +1 modulo 4.
    function automatic logic [1:0] cw_phase(input logic [1:0] code);
        return {code[1], code[1] ^ code[0]};
    endfunction

    // Warm-up and debounce. During the first three edges after reset the
    // filter simply follows the synchroniser, so the idle level of the pins
    // (usually 11) is adopted silently instead of being decoded as motion.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        warm_active = (warm_q != WARM_DONE);
        warm_d      = warm_active ? warm_q + 2'd1 : warm_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        cnt_d       = cnt_q;
        if (warm_active) begin
            filt_d      = sync_q;
            filt_prev_d = sync_q;
            cnt_d[0]    = '0;
            cnt_d[1]    = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == '1) begin
                        filt_d[i] = sync_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DEBOUNCEWIDTH'(1);
                    end
                end else begin
                    // One cycle of agreement throws away a partial count.
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // Quadrature decode of the filtered pair against its previous value.
    // delta = 1 is a CW quarter, 3 a CCW quarter, 2 means both pins moved.
    always_comb begin
        delta       = cw_phase(filt_q) - cw_phase(filt_prev_q);
        quarter_d   = quarter_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        err_d       = 1'b0;
        if (!warm_active) begin
            unique case (delta)
                2'd1: begin
                    if (quarter_q == 3'sd3) begin
                        quarter_d = 3'sd0;
                        step_up_d = 1'b1;
                    end else begin
                        quarter_d = quarter_q + 3'sd1;
                    end
                end
                2'd3: begin
                    if (quarter_q == -3'sd3) begin
                        quarter_d   = 3'sd0;
                        step_down_d = 1'b1;
                    end else begin
                        quarter_d = quarter_q - 3'sd1;
                    end
                end
                2'd2: begin
                    quarter_d = 3'sd0;
                    err_d     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Paddle position moves on the same edge the step pulse is registered.
    always_comb begin
        position_d = position_q;
        if (center) begin
            position_d = POS_INIT;
        end else if (!hold) begin
            if (step_up_d && (position_q < POS_MAX)) begin
                position_d = position_q + POS_ONE;
            end else if (step_down_d && (position_q != '0)) begin
                position_d = position_q - POS_ONE;
            end
        end
    end

    always_ff @(posedge clk32mhz) begin
        if (!reset_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            // NOTE: cnt_q is only two flop registers, not a RAM, so it is
            // reset like any other state.
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            warm_q      <= '0;
            quarter_q   <= 3'sd0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            err_q       <= 1'b0;
            position_q  <= POS_INIT;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what the synchroniser chain relies on.
            meta_q      <= {enc_a, enc_b};
            sync_q      <= meta_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            quarter_q   <= quarter_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            err_q       <= err_d;
            position_q  <= position_d;
        end
    end

    assign position  = position_q;
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign err       = err_q;

endmodule

// File: tb/tb_paddle_encoder.sv
// -----------------------------------------------------------------------------
// tb_paddle_encoder
//
// Bench for paddle_encoder with DEBOUNCEWIDTH=2. Every cycle the DUT outputs
// are compared with a behavioural model that tracks pins as sample histories,
// the detent as an integer quarter count and the paddle as a clamped integer.
// A table of encoder phases with expected positions and pulse counts covers
// the main detent behaviour; hand-written sequences cover warm-up, glitches,
// simultaneous pin changes, center/hold interaction and reset mid-detent;
// a randomized walk finishes the run.
// -----------------------------------------------------------------------------
module tb_paddle_encoder;

    localparam int DW      = 2;
    localparam int PW      = 4;
    localparam int PMAX    = 13;
    localparam int PINIT   = 6;
    localparam int DEB_LEN = 1 << DW;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          enc_a   = 1'b0;
    logic          enc_b   = 1'b0;
    logic          center  = 1'b0;
    logic          hold    = 1'b0;
    logic [PW-1:0] position;
    logic          step_up;
    logic          step_down;
    logic          err;

    paddle_encoder #(
        .DEBOUNCEWIDTH(DW),
        .POSWIDTH     (PW),
        .PADDLE_MAX   (PMAX),
        .PADDLE_INIT  (PINIT)
    ) dut (
        .clk32mhz (clk),
        .reset_n  (reset_n),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .center   (center),
        .hold     (hold),
        .position (position),
        .step_up  (step_up),
        .step_down(step_down),
        .err      (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int dut_up      = 0;
    int dut_dn      = 0;
    int dut_err     = 0;

    // CW rotation visits these codes in order ({A,B}).
    logic [1:0] cw_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // ---------------- behavioural model ----------------
    logic [1:0] m_raw1, m_raw2;      // raw samples 1 and 2 edges old
    logic [1:0] m_f, m_fprev;
    int         m_streak [2];
    int         m_q, m_pos, m_warm;
    bit         m_up, m_dn, m_err;

    function automatic int cw_index(input logic [1:0] code);
        for (int i = 0; i < 4; i++) if (cw_seq[i] == code) return i;
        return 0;
    endfunction

    function automatic void model_step();
        logic [1:0] seen;
        logic [1:0] new_f;
        logic [1:0] new_fprev;
        int         steps;
        if (!reset_n) begin
            m_raw1 = 2'b00; m_raw2 = 2'b00;
            m_f = 2'b00; m_fprev = 2'b00;
            m_streak[0] = 0; m_streak[1] = 0;
            m_q = 0; m_pos = PINIT; m_warm = 3;
            m_up = 0; m_dn = 0; m_err = 0;
            return;
        end
        m_up = 0; m_dn = 0; m_err = 0;
        if (m_warm == 0) begin
            steps = (cw_index(m_f) - cw_index(m_fprev) + 4) % 4;
            if (steps == 1) begin
                m_q++;
                if (m_q == 4) begin m_q = 0; m_up = 1; end
            end else if (steps == 3) begin
                m_q--;
                if (m_q == -4) begin m_q = 0; m_dn = 1; end
            end else if (steps == 2) begin
                m_q = 0; m_err = 1;
            end
        end
        if (center)              m_pos = PINIT;
        else if (!hold && m_up)  m_pos = (m_pos < PMAX) ? m_pos + 1 : m_pos;
        else if (!hold && m_dn)  m_pos = (m_pos > 0) ? m_pos - 1 : m_pos;
        // The filter sees the raw level from two edges ago.
        seen      = m_raw2;
        new_f     = m_f;
        new_fprev = m_f;
        if (m_warm > 0) begin
            new_f = seen; new_fprev = seen;
            m_streak[0] = 0; m_streak[1] = 0;
            m_warm--;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (seen[i] != m_f[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DEB_LEN) begin
                        new_f[i] = seen[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
        end
        m_raw2 = m_raw1;
        m_raw1 = {enc_a, enc_b};
        m_f = new_f;
        m_fprev = new_fprev;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("position", position, m_pos);
        check("step_up", step_up, m_up);
        check("step_down", step_down, m_dn);
        check("err", err, m_err);
        dut_up  += int'(step_up === 1'b1);
        dut_dn  += int'(step_down === 1'b1);
        dut_err += int'(err === 1'b1);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic phase(input logic [1:0] ab, input int n);
        {enc_a, enc_b} = ab;
        run(n);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        {enc_a, enc_b} = ab;
        reset_n = 1'b0;
        run(2);
        reset_n = 1'b1;
        run(10);
    endtask

    // ---------------- table of encoder phases ----------------
    typedef struct {
        logic [1:0] ab;
        logic       hold_v;
        int         cycles;
        int         exp_pos;
        int         exp_up;
        int         exp_dn;
        int         exp_err;
    } vec_t;

    vec_t tbl [$];

    // One detent from 00 back to 00; the pulse lands in the final phase.
    function automatic void add_detent(input bit cw, input bit hv, input int pos_before, input int pos_after);
        logic [1:0] cw_codes  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [1:0] ccw_codes [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            vec_t v;
            v.ab      = cw ? cw_codes[i] : ccw_codes[i];
            v.hold_v  = hv;
            v.cycles  = 10;
            v.exp_pos = (i == 3) ? pos_after : pos_before;
            v.exp_up  = (i == 3 && cw) ? 1 : 0;
            v.exp_dn  = (i == 3 && !cw) ? 1 : 0;
            v.exp_err = 0;
            tbl.push_back(v);
        end
    endfunction

    initial begin
        int p;
        int up0, dn0, err0;
        int idx;

        // Build the table with a running expected position.
        p = PINIT;
        add_detent(1, 0, p, p + 1); p = p + 1;
        add_detent(0, 0, p, p - 1); p = p - 1;
        for (int i = 0; i < 8; i++) begin
            add_detent(1, 0, p, (p < PMAX) ? p + 1 : p);
            p = (p < PMAX) ? p + 1 : p;
        end
        for (int i = 0; i < 14; i++) begin
            add_detent(0, 0, p, (p > 0) ? p - 1 : p);
            p = (p > 0) ? p - 1 : p;
        end
        add_detent(1, 1, p, p);
        add_detent(1, 0, p, p + 1); p = p + 1;

        // Reset with pins idling at 11: warm-up must absorb it silently.
        {enc_a, enc_b} = 2'b11;
        reset_n = 1'b0;
        run(2);
        check("reset_pos", position, PINIT);
        check("reset_up", step_up, 0);
        reset_n = 1'b1;
        err0 = dut_err;
        run(10);
        check("warmup_err", dut_err - err0, 0);
        check("warmup_pos", position, PINIT);

        // Clean start from 00, then the table.
        do_reset(2'b00);
        foreach (tbl[r]) begin
            up0 = dut_up; dn0 = dut_dn; err0 = dut_err;
            hold = tbl[r].hold_v;
            phase(tbl[r].ab, tbl[r].cycles);
            check("tbl_pos", position, tbl[r].exp_pos);
            check("tbl_up", dut_up - up0, tbl[r].exp_up);
            check("tbl_dn", dut_dn - dn0, tbl[r].exp_dn);
            check("tbl_err", dut_err - err0, tbl[r].exp_err);
        end
        hold = 1'b0;

        // Glitches on A shorter than the debounce window, split by one
        // agreeing cycle: never accepted.
        up0 = dut_up; dn0 = dut_dn; err0 = dut_err;
        phase(2'b10, 3);
        phase(2'b00, 1);
        phase(2'b10, 3);
        phase(2'b00, 12);
        check("glitch_pulses", (dut_up - up0) + (dut_dn - dn0) + (dut_err - err0), 0);
        check("glitch_pos", position, 1);

        // Simultaneous change 00->11 raises err and clears a partial detent.
        err0 = dut_err;
        phase(2'b11, 10);
        check("simul_err1", dut_err - err0, 1);
        phase(2'b10, 10);
        phase(2'b00, 10);          // q now +2
        up0 = dut_up;
        phase(2'b11, 10);          // err again, q back to 0
        check("simul_err2", dut_err - err0, 2);
        check("simul_pos", position, 1);
        phase(2'b10, 10);
        phase(2'b00, 10);
        phase(2'b01, 10);
        check("simul_no_early_up", dut_up - up0, 0);
        phase(2'b11, 10);
        check("simul_one_up", dut_up - up0, 1);
        check("simul_pos_after", position, 2);

        // center on the exact edge of a step_up pulse.
        do_reset(2'b00);
        for (int i = 0; i < 2; i++) begin
            phase(2'b01, 10); phase(2'b11, 10); phase(2'b10, 10); phase(2'b00, 10);
        end
        check("pre_center_pos", position, 8);
        phase(2'b01, 10); phase(2'b11, 10); phase(2'b10, 10);
        phase(2'b00, 6);
        center = 1'b1;
        tick();                    // 7th edge after the last raw change
        check("center_pulse", step_up, 1);
        check("center_pos", position, PINIT);
        center = 1'b0;
        run(5);

        // Reset after two CW quarters discards the partial detent.
        phase(2'b01, 10);
        phase(2'b11, 10);
        do_reset(2'b11);
        check("midreset_pos", position, PINIT);
        up0 = dut_up;
        phase(2'b10, 10);
        phase(2'b00, 10);
        phase(2'b01, 10);
        check("midreset_no_early_up", dut_up - up0, 0);
        phase(2'b11, 10);
        check("midreset_one_up", dut_up - up0, 1);
        check("midreset_pos_after", position, PINIT + 1);

        // Randomized walk checked cycle by cycle against the model.
        idx = 2;                   // pins currently at 11
        for (int n = 0; n < 300; n++) begin
            int r;
            int len;
            r   = $urandom_range(0, 99);
            len = $urandom_range(5, 14);
            hold = ($urandom_range(0, 9) == 0);
            if (r < 70) begin
                idx = (idx + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
                {enc_a, enc_b} = cw_seq[idx];
            end else if (r < 80) begin
                idx = (idx + 2) % 4;
                {enc_a, enc_b} = cw_seq[idx];
            end else if (r < 95) begin
                {enc_a, enc_b} = cw_seq[(idx + 1) % 4];
                run($urandom_range(1, 4));
                {enc_a, enc_b} = cw_seq[idx];
            end else begin
                reset_n = 1'b0;
                run($urandom_range(1, 2));
                reset_n = 1'b1;
            end
            for (int k = 0; k < len; k++) begin
                center = ($urandom_range(0, 19) == 0);
                tick();
            end
            center = 1'b0;
        end
        hold = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
